// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module sync_fifo_param #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] din,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic [AW-1:0]    wrptr,
    output logic [AW-1:0]    rdptr,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0] AF_C    = AF_LEVEL[AW:0];
    localparam logic [AW:0] AE_C    = AE_LEVEL[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wrptr_q, wrptr_d;
    logic [AW-1:0] rdptr_q, rdptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic wr_acc;
    logic rd_acc;

    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);

    // A full FIFO still accepts a write when a pop frees the slot on the same edge.
    assign wr_acc = wr && (!full || rd);
    assign rd_acc = rd && !empty;

    always_comb begin
        wrptr_d     = wrptr_q;
        rdptr_d     = rdptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_acc) begin
            wrptr_d = wrptr_q + 1'b1;
        end
        if (rd_acc) begin
            rdptr_d = rdptr_q + 1'b1;
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
        if (wr && full && !rd) begin
            overflow_d = 1'b1;
        end
        if (rd && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrptr_q     <= '0;
            rdptr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrptr_q     <= wrptr_d;
            rdptr_q     <= rdptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wrptr_q] <= din;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign dout = empty ? '0 : mem[rdptr_q];
`else
    logic [WIDTH-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            dout_q <= mem[rdptr_q];
        end
    end

    assign dout = dout_q;
`endif

    assign wrptr     = wrptr_q;
    assign rdptr     = rdptr_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param against a queue-based model.
// Follows SYNC_FIFO_FWFT_EN to choose the expected read timing.
module tb_sync_fifo_param;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int AFL   = 14;
    localparam int AEL   = 2;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             wr  = 1'b0;
    logic             rd  = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] dout;
    logic [AW-1:0]    wrptr;
    logic [AW-1:0]    rdptr;
    logic [AW:0]      count;
    logic             full, empty, almost_full, almost_empty;
    logic             overflow, underflow;

    int total = 0;
    int bad   = 0;

    sync_fifo_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL)
    ) dut (
        .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd),
        .dout(dout), .wrptr(wrptr), .rdptr(rdptr), .count(count),
        .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue, pointers as write/read totals.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_dout;
    bit               m_ovf, m_unf, m_valid;
    int               m_wcnt, m_rcnt;
    bit               m_full, m_empty;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ovf   = 0;
            m_unf   = 0;
            m_dout  = '0;
            m_wcnt  = 0;
            m_rcnt  = 0;
            m_valid = 1;
        end else if (m_valid) begin
            m_full  = (q.size() == DEPTH);
            m_empty = (q.size() == 0);
            if (wr && m_full && !rd) m_ovf = 1;
            if (rd && m_empty) m_unf = 1;
            if (rd && !m_empty) begin
                m_dout = q.pop_front();
                m_rcnt++;
            end
            if (wr && (!m_full || rd)) begin
                q.push_back(din);
                m_wcnt++;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_dout();
`ifdef SYNC_FIFO_FWFT_EN
        return (q.size() != 0) ? int'(q[0]) : 0;
`else
        return int'(m_dout);
`endif
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            check("count", int'(count), q.size());
            check("full", int'(full), int'(q.size() == DEPTH));
            check("empty", int'(empty), int'(q.size() == 0));
            check("almost_full", int'(almost_full), int'(q.size() >= AFL));
            check("almost_empty", int'(almost_empty), int'(q.size() <= AEL));
            check("wrptr", int'(wrptr), m_wcnt % DEPTH);
            check("rdptr", int'(rdptr), m_rcnt % DEPTH);
            check("dout", int'(dout), exp_dout());
            check("overflow", int'(overflow), int'(m_ovf));
            check("underflow", int'(underflow), int'(m_unf));
        end
    end

    task automatic step(input bit w, input logic [WIDTH-1:0] d,
                        input bit r, input bit rs = 0);
        wr  = w;
        din = d;
        rd  = r;
        rst = rs;
        @(posedge clk);
        #1;
        wr  = 0;
        rd  = 0;
        rst = 0;
    endtask

    task automatic do_reset();
        step(0, '0, 0, 1);
    endtask

    int saved;

    initial begin
        #2;
        // 1: reset values
        do_reset();
        check("rst count", int'(count), 0);
        check("rst empty", int'(empty), 1);
        check("rst full", int'(full), 0);
        check("rst ae", int'(almost_empty), 1);
        check("rst af", int'(almost_full), 0);
        check("rst ptrs", int'({wrptr, rdptr}), 0);
        check("rst dout", int'(dout), 0);
        check("rst errs", int'({overflow, underflow}), 0);

        // 2: fill then drain in order
        for (int i = 1; i <= 16; i++) begin
            step(1, 16'(i), 0);
            check("t2 af", int'(almost_full), int'(i >= 14));
        end
        check("t2 full", int'(full), 1);
        for (int i = 1; i <= 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            check("t2 dout", int'(dout), i);
            step(0, '0, 1);
`else
            step(0, '0, 1);
            check("t2 dout", int'(dout), i);
`endif
        end
        check("t2 empty", int'(empty), 1);

        // 3: overflow, then underflow
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 16'(16'h0100 + i), 0);
        step(1, 16'hDEAD, 0);
        check("t3 overflow", int'(overflow), 1);
        check("t3 count", int'(count), 16);
        check("t3 wrptr", int'(wrptr), 0);
        for (int i = 0; i < 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            check("t3 dout", int'(dout), 16'h0100 + i);
            step(0, '0, 1);
`else
            step(0, '0, 1);
            check("t3 dout", int'(dout), 16'h0100 + i);
`endif
        end
        saved = int'(rdptr);
        step(0, '0, 1);
        check("t3 underflow", int'(underflow), 1);
        check("t3 rdptr", int'(rdptr), saved);

        // 4: full with simultaneous wr/rd across the wrap
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 16'(16'h0200 + i), 0);
        for (int i = 0; i < 20; i++) step(1, 16'(16'h0300 + i), 1);
        check("t4 count", int'(count), 16);
        check("t4 full", int'(full), 1);
        check("t4 overflow", int'(overflow), 0);

        // 5: simultaneous wr/rd on empty
        do_reset();
        step(1, 16'hA5A5, 1);
        check("t5 count", int'(count), 1);
        check("t5 underflow", int'(underflow), 1);
`ifdef SYNC_FIFO_FWFT_EN
        check("t5 dout", int'(dout), 16'hA5A5);
        step(0, '0, 1);
`else
        step(0, '0, 1);
        check("t5 dout", int'(dout), 16'hA5A5);
`endif

        // 6: reset mid-stream discards contents
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 16'(16'h0400 + i), 0);
        step(1, 16'hBEEF, 0, 1);
        check("t6 count", int'(count), 0);
        check("t6 empty", int'(empty), 1);
        check("t6 dout", int'(dout), 0);
        check("t6 wrptr", int'(wrptr), 0);
        step(1, 16'h0500, 0);
        step(1, 16'h0501, 0);
        for (int i = 0; i < 2; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            check("t6 post", int'(dout), 16'h0500 + i);
            step(0, '0, 1);
`else
            step(0, '0, 1);
            check("t6 post", int'(dout), 16'h0500 + i);
`endif
        end

        // 7: random traffic with phases biased towards full and empty
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int wp;
            wp = ((i / 300) % 2 == 0) ? 70 : 30;
            step($urandom_range(99, 0) < wp, 16'($urandom),
                 $urandom_range(99, 0) < (100 - wp),
                 $urandom_range(399, 0) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
